// File: rtl/mc_req_queue_if.sv
`default_nettype none
// ============================================================================
// mc_req_queue_if : parser-side and DRAM-command-side valid/ready channels
// Revision 1.0
// ============================================================================
interface mc_req_queue_if #(
   parameter int ADDR_WIDTH = 36,
   parameter int OP_WIDTH   = 2,
   parameter int TIME_WIDTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [TIME_WIDTH-1:0] in_time;
   logic [OP_WIDTH-1:0]   in_op;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic                  out_valid;
   logic                  out_ready;
   logic [TIME_WIDTH-1:0] out_time;
   logic [OP_WIDTH-1:0]   out_op;
   logic [ADDR_WIDTH-1:0] out_addr;

   modport master (
      output in_valid, in_time, in_op, in_addr, out_ready,
      input  in_ready, out_valid, out_time, out_op, out_addr
   );

   modport slave (
      input  in_valid, in_time, in_op, in_addr, out_ready,
      output in_ready, out_valid, out_time, out_op, out_addr
   );
endinterface
`default_nettype wire

// File: rtl/mc_req_queue_ctrl.sv
`default_nettype none
// ============================================================================
// mc_req_queue_ctrl : timestamp-gated request FIFO with order/opcode checking
// Revision 1.0
// ============================================================================
module mc_req_queue_ctrl #(
   parameter int ADDR_WIDTH = 36,
   parameter int OP_WIDTH   = 2,
   parameter int TIME_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = 5
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   mc_req_queue_if.slave              q,
   output logic      [CNT_WIDTH-1:0]  count,
   output logic                       full,
   output logic                       empty,
   output logic      [TIME_WIDTH-1:0] sys_time,
   output logic                       err_order,
   output logic                       err_op,
   output logic      [7:0]            err_cnt
);
   localparam int              c_PTR_W      = $clog2(DEPTH);
   localparam logic [OP_WIDTH-1:0] c_OP_ILLEGAL = OP_WIDTH'(3);

   logic [TIME_WIDTH-1:0] r_mem_time [DEPTH];
   logic [OP_WIDTH-1:0]   r_mem_op   [DEPTH];
   logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];

   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_count;
   logic [TIME_WIDTH-1:0] r_sys_time;
   logic [TIME_WIDTH-1:0] r_last_time;
   logic                  r_err_order;
   logic                  r_err_op;
   logic [7:0]            r_err_cnt;

   logic w_full;
   logic w_empty;
   logic w_hs;
   logic w_illegal;
   logic w_order_bad;
   logic w_store;
   logic w_pop;

   assign w_full      = (r_count == CNT_WIDTH'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign q.in_ready  = !w_full && (q.in_time <= r_sys_time);
   assign w_hs        = q.in_valid && q.in_ready;
   assign w_illegal   = (q.in_op == c_OP_ILLEGAL);
   assign w_order_bad = (q.in_time < r_last_time);
   assign w_store     = w_hs && !w_illegal && !w_order_bad;
   assign w_pop       = !w_empty && q.out_ready;

   // Head is read straight from storage; no bypass, so a push shows next cycle.
   assign q.out_valid = !w_empty;
   assign q.out_time  = r_mem_time[r_rd_ptr];
   assign q.out_op    = r_mem_op[r_rd_ptr];
   assign q.out_addr  = r_mem_addr[r_rd_ptr];

   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign sys_time  = r_sys_time;
   assign err_order = r_err_order;
   assign err_op    = r_err_op;
   assign err_cnt   = r_err_cnt;

   always_ff @(posedge clk) begin
      if (!rst && w_store) begin
         r_mem_time[r_wr_ptr] <= q.in_time;
         r_mem_op[r_wr_ptr]   <= q.in_op;
         r_mem_addr[r_wr_ptr] <= q.in_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_sys_time  <= '0;
         r_last_time <= '0;
         r_err_order <= 1'b0;
         r_err_op    <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         if (r_sys_time != '1) begin
            r_sys_time <= r_sys_time + TIME_WIDTH'(1);
         end
         if (w_store) begin
            r_wr_ptr    <= r_wr_ptr + c_PTR_W'(1);
            r_last_time <= q.in_time;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         r_count <= r_count + CNT_WIDTH'(w_store) - CNT_WIDTH'(w_pop);
         // An illegal opcode masks the ordering error for the same request.
         r_err_op    <= w_hs && w_illegal;
         r_err_order <= w_hs && !w_illegal && w_order_bad;
         if (w_hs && (w_illegal || w_order_bad) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mc_req_queue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mc_req_queue_ctrl : directed self-checking bench for mc_req_queue_ctrl
// Revision 1.0
// ============================================================================
module tb_mc_req_queue_ctrl;
   logic        clk;
   logic        rst;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic [15:0] sys_time;
   logic        err_order;
   logic        err_op;
   logic [7:0]  err_cnt;
   int          n_cmp;
   int          n_fail;

   mc_req_queue_if #(.ADDR_WIDTH(36), .OP_WIDTH(2), .TIME_WIDTH(16)) bus ();

   mc_req_queue_ctrl #(
      .ADDR_WIDTH(36), .OP_WIDTH(2), .TIME_WIDTH(16), .DEPTH(16), .CNT_WIDTH(5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .q        (bus.slave),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .sys_time (sys_time),
      .err_order(err_order),
      .err_op   (err_op),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      step();
      rst = 1'b0;
   endtask

   // Holds the request until it is taken; leaves us one tick after the taking edge.
   task automatic push(input logic [15:0] t, input logic [1:0] op, input logic [35:0] a);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_time = t;
      bus.in_op = op;
      bus.in_addr = a;
      #1;
      while (!bus.in_ready && n < 200) begin
         step();
         n++;
      end
      if (!bus.in_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL push_timeout: in_ready=%0b required 1", bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({sys_time, count, empty, full, bus.out_valid, err_order, err_op, err_cnt} !==
          {16'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_state: sys_time=%0d count=%0d empty=%0b full=%0b ov=%0b eo=%0b ep=%0b ec=%0d required 0 0 1 0 0 0 0 0",
                  sys_time, count, empty, full, bus.out_valid, err_order, err_op, err_cnt);
      end
   endtask

   task automatic test_time_gating();
      logic        done;
      logic [15:0] hs_time;
      do_reset();
      done = 1'b0;
      hs_time = '0;
      bus.in_valid = 1'b1;
      bus.in_time = 16'd5;
      bus.in_op = 2'd0;
      bus.in_addr = 36'h01FF97000;
      for (int c = 0; c < 20 && !done; c++) begin
         #1;
         n_cmp++;
         if (bus.in_ready !== (sys_time >= 16'd5) || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_ready: sys_time=%0d in_ready=%0b out_valid=%0b required %0b 0",
                     sys_time, bus.in_ready, bus.out_valid, sys_time >= 16'd5);
         end
         if (bus.in_ready) begin
            hs_time = sys_time;
            done = 1'b1;
         end
         step();
      end
      bus.in_valid = 1'b0;
      n_cmp++;
      if (hs_time !== 16'd5 || sys_time !== 16'd6 || bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL gate_latency: hs_time=%0d sys_time=%0d out_valid=%0b required 5 6 1",
                  hs_time, sys_time, bus.out_valid);
      end
      n_cmp++;
      if (bus.out_time !== 16'd5 || bus.out_op !== 2'd0 || bus.out_addr !== 36'h01FF97000) begin
         n_fail++;
         $display("FAIL gate_fields: time=%0d op=%0d addr=%h required 5 0 01ff97000",
                  bus.out_time, bus.out_op, bus.out_addr);
      end
   endtask

   task automatic test_fill_wrap();
      int j;
      int k;
      do_reset();
      for (int i = 0; i < 16; i++) push(16'(i), 2'd0, 36'(i));
      n_cmp++;
      if (count !== 5'd16 || full !== 1'b1 || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_full: count=%0d full=%0b empty=%0b required 16 1 0", count, full, empty);
      end
      bus.in_valid = 1'b1;
      bus.in_time = 16'd15;
      bus.in_op = 2'd0;
      bus.in_addr = 36'd16;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_17th_ready: in_ready=%0b required 0", bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      n_cmp++;
      if (count !== 5'd16) begin
         n_fail++;
         $display("FAIL fill_17th_count: count=%0d required 16", count);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_addr !== 36'(i)) begin
            n_fail++;
            $display("FAIL drain_order: out_valid=%0b addr=%0d required 1 %0d", bus.out_valid, bus.out_addr, i);
         end
         step();
      end
      n_cmp++;
      if (empty !== 1'b1 || count !== 5'd0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: empty=%0b count=%0d out_valid=%0b required 1 0 0", empty, count, bus.out_valid);
      end
      j = 0;
      k = 0;
      for (int c = 0; c < 100 && k < 20; c++) begin
         bus.in_valid = (j < 20);
         bus.in_time = 16'd20;
         bus.in_op = 2'd1;
         bus.in_addr = 36'(100 + j);
         #1;
         if (bus.out_valid) begin
            n_cmp++;
            if (bus.out_addr !== 36'(100 + k)) begin
               n_fail++;
               $display("FAIL wrap_order: addr=%0d required %0d", bus.out_addr, 100 + k);
            end
            k++;
         end
         if (bus.in_valid && bus.in_ready) j++;
         step();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      n_cmp++;
      if (k !== 20 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_done: popped=%0d empty=%0b required 20 1", k, empty);
      end
   endtask

   task automatic test_order_check();
      do_reset();
      push(16'd10, 2'd0, 36'hA);
      push(16'd8, 2'd0, 36'hB);
      n_cmp++;
      if (err_order !== 1'b1 || err_op !== 1'b0 || err_cnt !== 8'd1 || count !== 5'd1) begin
         n_fail++;
         $display("FAIL order_drop: err_order=%0b err_op=%0b err_cnt=%0d count=%0d required 1 0 1 1",
                  err_order, err_op, err_cnt, count);
      end
      step();
      n_cmp++;
      if (err_order !== 1'b0) begin
         n_fail++;
         $display("FAIL order_pulse_width: err_order=%0b required 0", err_order);
      end
      push(16'd10, 2'd2, 36'hC);
      n_cmp++;
      if (count !== 5'd2 || err_order !== 1'b0 || err_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL order_equal_ok: count=%0d err_order=%0b err_cnt=%0d required 2 0 1",
                  count, err_order, err_cnt);
      end
   endtask

   task automatic test_illegal_op();
      do_reset();
      push(16'd0, 2'd3, 36'h1);
      n_cmp++;
      if (err_op !== 1'b1 || err_order !== 1'b0 || err_cnt !== 8'd1 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL illegal_op: err_op=%0b err_order=%0b err_cnt=%0d empty=%0b required 1 0 1 1",
                  err_op, err_order, err_cnt, empty);
      end
      step();
      n_cmp++;
      if (err_op !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_pulse_width: err_op=%0b required 0", err_op);
      end
      push(16'd5, 2'd0, 36'h2);
      push(16'd2, 2'd3, 36'h3);
      n_cmp++;
      if (err_op !== 1'b1 || err_order !== 1'b0 || err_cnt !== 8'd2 || count !== 5'd1) begin
         n_fail++;
         $display("FAIL illegal_and_order: err_op=%0b err_order=%0b err_cnt=%0d count=%0d required 1 0 2 1",
                  err_op, err_order, err_cnt, count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      push(16'd0, 2'd0, 36'hA);
      push(16'd0, 2'd0, 36'hB);
      push(16'd0, 2'd0, 36'hC);
      bus.in_valid = 1'b1;
      bus.in_time = 16'd0;
      bus.in_op = 2'd1;
      bus.in_addr = 36'hD;
      bus.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (count !== 5'd3 || bus.in_ready !== 1'b1 || bus.out_addr !== 36'hA) begin
         n_fail++;
         $display("FAIL pushpop_before: count=%0d in_ready=%0b head=%h required 3 1 a",
                  count, bus.in_ready, bus.out_addr);
      end
      step();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      n_cmp++;
      if (count !== 5'd3 || bus.out_addr !== 36'hB) begin
         n_fail++;
         $display("FAIL pushpop_after: count=%0d head=%h required 3 b", count, bus.out_addr);
      end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      push(16'd0, 2'd3, 36'h0);
      for (int i = 0; i < 7; i++) push(16'd0, 2'd0, 36'(i + 1));
      n_cmp++;
      if (count !== 5'd7 || err_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL midrst_setup: count=%0d err_cnt=%0d required 7 1", count, err_cnt);
      end
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_time = 16'd0;
      bus.in_op = 2'd0;
      bus.in_addr = 36'h55;
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      n_cmp++;
      if (count !== 5'd0 || bus.out_valid !== 1'b0 || sys_time !== 16'd0 || err_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL midrst_state: count=%0d out_valid=%0b sys_time=%0d err_cnt=%0d required 0 0 0 0",
                  count, bus.out_valid, sys_time, err_cnt);
      end
      step();
      n_cmp++;
      if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_not_stored: empty=%0b out_valid=%0b required 1 0", empty, bus.out_valid);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_time = '0;
      bus.in_op = '0;
      bus.in_addr = '0;
      bus.out_ready = 1'b0;
      step();
      test_reset();
      test_time_gating();
      test_fill_wrap();
      test_order_check();
      test_illegal_op();
      test_back_to_back();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
